// File: rtl/ysyx_25040109_pkg.sv
// Shared constants and FSM state type for the load/store unit.
package ysyx_25040109_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/ysyx_25040109_lsu_align.sv
// Combinational helpers for the LSU: request legality, store byte mask,
// and load byte/half/word extraction with sign or zero extension.
module ysyx_25040109_lsu_align
  import ysyx_25040109_pkg::*;
(
  input  logic [1:0]  chk_addr,
  input  logic [1:0]  chk_size,
  input  logic        chk_ren,
  input  logic        chk_wen,
  output logic        chk_illegal,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] load_data
);

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
    logic signed [31:0] ext;
    ext = {{24{b[7]}}, b};
    return uns ? {24'd0, b} : ext;
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic uns);
    logic signed [31:0] ext;
    ext = {{16{h[15]}}, h};
    return uns ? {16'd0, h} : ext;
  endfunction

  logic [31:0] shifted;
  logic [3:0]  base_mask;

  always_comb begin
    chk_illegal = (chk_ren == chk_wen)
               || (chk_size == 2'd3)
               || ((chk_size == SIZE_H) && chk_addr[0])
               || ((chk_size == SIZE_W) && (chk_addr != 2'd0));
  end

  always_comb begin
    case (size)
      SIZE_B:  base_mask = 4'b0001;
      SIZE_H:  base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    wmask = base_mask << addr_lo;
  end

  // Memory returns the whole aligned word; shift the addressed lane down first.
  always_comb begin
    shifted = rword >> {addr_lo, 3'b000};
    case (size)
      SIZE_B:  load_data = extend_byte(shifted[7:0], is_unsigned);
      SIZE_H:  load_data = extend_half(shifted[15:0], is_unsigned);
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: one request at a time from EXU, AXI-lite-style read or
// address+data write to dmem, aligned/extended response with tag to WBU.
module ysyx_25040109_lsu
  import ysyx_25040109_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic             req_ren,
  input  logic             req_wen,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      dmem_araddr,
  output logic             dmem_arvalid,
  input  logic             dmem_arready,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_rvalid,
  output logic             dmem_rready,
  output logic [31:0]      dmem_awaddr,
  output logic             dmem_awvalid,
  input  logic             dmem_awready,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_wmask,
  output logic             dmem_wen,
  output logic             dmem_wvalid,
  input  logic             dmem_wready
);

  lsu_state_t       state, state_nxt;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [1:0]       size_q;
  logic             unsigned_q, err_q;
  logic [TAG_W-1:0] tag_q;
  logic             aw_done, w_done;
  logic             req_fire, illegal, aw_fire, w_fire;
  logic [31:0]      load_data;
  logic [3:0]       wmask;

  ysyx_25040109_lsu_align u_align (
    .chk_addr    (req_addr[1:0]),
    .chk_size    (req_size),
    .chk_ren     (req_ren),
    .chk_wen     (req_wen),
    .chk_illegal (illegal),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rword       (dmem_rdata),
    .wmask       (wmask),
    .load_data   (load_data)
  );

  assign req_fire = req_valid && (state == IDLE);
  assign aw_fire  = dmem_awvalid && dmem_awready;
  assign w_fire   = dmem_wvalid && dmem_wready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_fire) begin
        if (illegal)      state_nxt = RESP;
        else if (req_ren) state_nxt = RD_A;
        else              state_nxt = WR;
      end
      RD_A: if (dmem_arready) state_nxt = RD_D;
      RD_D: if (dmem_rvalid)  state_nxt = RESP;
      WR:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = RESP;
      RESP: if (resp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state == IDLE);
    dmem_arvalid = (state == RD_A);
    dmem_rready  = (state == RD_D);
    dmem_awvalid = (state == WR) && !aw_done;
    dmem_wvalid  = (state == WR) && !w_done;
    dmem_wen     = (state == WR);
    resp_valid   = (state == RESP);
    dmem_araddr  = addr_q;
    dmem_awaddr  = addr_q;
    dmem_wdata   = wdata_q;
    dmem_wmask   = wmask;
    resp_rdata   = rdata_q;
    resp_err     = err_q;
    resp_tag     = tag_q;
  end

  // Request latch and per-channel write completion; each write channel retires independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      tag_q      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_fire) begin
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          size_q     <= req_size;
          unsigned_q <= req_unsigned;
          tag_q      <= req_tag;
          err_q      <= illegal;
          rdata_q    <= '0;
          aw_done    <= 1'b0;
          w_done     <= 1'b0;
        end
        RD_D: if (dmem_rvalid) rdata_q <= load_data;
        WR: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Scoreboard bench for the LSU with a behavioural dmem that can insert random stalls.
module tb_ysyx_25040109_lsu;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [31:0]      req_addr, req_wdata;
  logic             req_ren, req_wen, req_unsigned;
  logic [1:0]       req_size;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid, resp_ready, resp_err;
  logic [31:0]      resp_rdata;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      dmem_araddr, dmem_rdata, dmem_awaddr, dmem_wdata;
  logic             dmem_arvalid, dmem_arready, dmem_rvalid, dmem_rready;
  logic             dmem_awvalid, dmem_awready, dmem_wen, dmem_wvalid, dmem_wready;
  logic [3:0]       dmem_wmask;

  ysyx_25040109_lsu #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ren(req_ren), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_tag(resp_tag),
    .dmem_araddr(dmem_araddr), .dmem_arvalid(dmem_arvalid), .dmem_arready(dmem_arready),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .dmem_rready(dmem_rready),
    .dmem_awaddr(dmem_awaddr), .dmem_awvalid(dmem_awvalid), .dmem_awready(dmem_awready),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_wen(dmem_wen),
    .dmem_wvalid(dmem_wvalid), .dmem_wready(dmem_wready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural data memory ----------------
  logic [31:0] mem [0:15];
  logic        stall_en = 1'b0, rv_block = 1'b0;
  logic        ar_rand = 1'b1, rv_rand = 1'b1, aw_rand = 1'b1, w_rand = 1'b1;
  logic        rd_pend, aw_seen;
  logic [31:0] rd_addr, aw_cap, wr_addr, wr_shift;
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wmask;
  logic        last_wen;
  int          ar_cycles = 0, aw_cycles = 0, w_cycles = 0;

  always @(negedge clk) begin
    ar_rand <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    rv_rand <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    aw_rand <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    w_rand  <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  assign dmem_arready = ar_rand;
  assign dmem_awready = aw_rand;
  assign dmem_rvalid  = rd_pend && rv_rand && !rv_block;
  assign dmem_rdata   = rd_pend ? mem[rd_addr[5:2]] : 32'hDEAD_BEEF;
  assign dmem_wready  = w_rand && (aw_seen || (dmem_awvalid && dmem_awready));
  assign wr_addr      = aw_seen ? aw_cap : dmem_awaddr;
  assign wr_shift     = dmem_wdata << {wr_addr[1:0], 3'b000};

  always @(posedge clk) begin
    if (dmem_arvalid) ar_cycles <= ar_cycles + 1;
    if (dmem_awvalid) aw_cycles <= aw_cycles + 1;
    if (dmem_wvalid)  w_cycles  <= w_cycles + 1;
    if (rst) begin
      rd_pend <= 1'b0;
      aw_seen <= 1'b0;
    end else begin
      if (dmem_arvalid && dmem_arready) begin
        rd_pend <= 1'b1;
        rd_addr <= dmem_araddr;
      end
      if (dmem_rvalid && dmem_rready) rd_pend <= 1'b0;
      if (dmem_awvalid && dmem_awready) begin
        aw_seen     <= 1'b1;
        aw_cap      <= dmem_awaddr;
        last_awaddr <= dmem_awaddr;
      end
      if (dmem_wvalid && dmem_wready) begin
        for (int b = 0; b < 4; b++)
          if (dmem_wmask[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_shift[8*b +: 8];
        last_wdata <= dmem_wdata;
        last_wmask <= dmem_wmask;
        last_wen   <= dmem_wen;
        aw_seen    <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard and reference ----------------
  typedef struct packed {
    logic [31:0]      rdata;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] shadow [0:15];
  int          vectors = 0, miscompares = 0;

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] lo,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lo +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    if (size == 2'd0) return uns ? 32'(b) : 32'($signed(b));
    if (size == 2'd1) return uns ? 32'(h) : 32'($signed(h));
    return word;
  endfunction

  function automatic logic ref_illegal(input logic [1:0] lo, input logic [1:0] size,
                                       input logic ren, input logic wen);
    if (ren == wen || size == 2'd3) return 1'b1;
    if (size == 2'd1) return lo[0];
    if (size == 2'd2) return lo != 2'd0;
    return 1'b0;
  endfunction

  task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata, input logic ren,
                           input logic wen, input logic [1:0] size, input logic uns,
                           input logic [TAG_W-1:0] tag);
    req_addr = addr; req_wdata = wdata; req_ren = ren; req_wen = wen;
    req_size = size; req_unsigned = uns; req_tag = tag; req_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    vectors++;
    if (!req_ready) begin
      miscompares++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    while (!resp_valid && n < 300) begin @(posedge clk); #1; n++; end
  endtask

  task automatic check_resp(input string name);
    exp_t e;
    vectors++;
    if (!resp_valid || sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s resp: resp_valid=%b required 1", name, resp_valid);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    vectors += 3;
    if (resp_rdata !== e.rdata) begin
      miscompares++; $display("FAIL %s rdata: got %h required %h", name, resp_rdata, e.rdata);
    end
    if (resp_err !== e.err) begin
      miscompares++; $display("FAIL %s err: got %b required %b", name, resp_err, e.err);
    end
    if (resp_tag !== e.tag) begin
      miscompares++; $display("FAIL %s tag: got %h required %h", name, resp_tag, e.tag);
    end
  endtask

  // Issues one request, pushes its expectation, and retires the response.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic ren,
                        input logic wen, input logic [1:0] size, input logic uns,
                        input logic [TAG_W-1:0] tag, input string name);
    exp_t e;
    e.err   = ref_illegal(addr[1:0], size, ren, wen);
    e.rdata = (e.err || !ren) ? 32'd0 : ref_load(shadow[addr[5:2]], addr[1:0], size, uns);
    e.tag   = tag;
    sb_q.push_back(e);
    if (!e.err && wen)
      for (int b = 0; b < 4; b++) begin
        logic [3:0]  m;
        logic [31:0] sh;
        m  = ((size == 2'd0) ? 4'b0001 : (size == 2'd1) ? 4'b0011 : 4'b1111) << addr[1:0];
        sh = wdata << (8 * addr[1:0]);
        if (m[b]) shadow[addr[5:2]][8*b +: 8] = sh[8*b +: 8];
      end
    drive_req(addr, wdata, ren, wen, size, uns, tag);
    wait_accept(name);
    wait_resp(name);
    check_resp(name);
    if (resp_valid) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    vectors += 6;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset req_ready: got %b required 1", req_ready); end
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset resp_valid: got %b required 0", resp_valid); end
    if (dmem_arvalid !== 1'b0 || dmem_rready !== 1'b0) begin
      miscompares++; $display("FAIL reset read: arvalid=%b rready=%b required 0 0", dmem_arvalid, dmem_rready);
    end
    if (dmem_awvalid !== 1'b0 || dmem_wvalid !== 1'b0) begin
      miscompares++; $display("FAIL reset write: awvalid=%b wvalid=%b required 0 0", dmem_awvalid, dmem_wvalid);
    end
    if (dmem_wen !== 1'b0) begin miscompares++; $display("FAIL reset wen: got %b required 0", dmem_wen); end
    if (resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      miscompares++; $display("FAIL reset data: err=%b rdata=%h required 0 0", resp_err, resp_rdata);
    end
  endtask

  task automatic test_loads;
    do_req(32'h8000_0001, 0, 1, 0, 2'd0, 0, 5'd3,  "lb");
    do_req(32'h8000_0001, 0, 1, 0, 2'd0, 1, 5'd4,  "lbu");
    do_req(32'h8000_0002, 0, 1, 0, 2'd1, 0, 5'd5,  "lh");
    do_req(32'h8000_0002, 0, 1, 0, 2'd1, 1, 5'd6,  "lhu");
    do_req(32'h8000_0000, 0, 1, 0, 2'd2, 0, 5'd31, "lw");
  endtask

  task automatic test_store;
    do_req(32'h8000_0003, 32'h0000_0012, 0, 1, 2'd0, 0, 5'd9, "sb");
    vectors += 4;
    if (last_awaddr !== 32'h8000_0003) begin miscompares++; $display("FAIL sb awaddr: got %h required 80000003", last_awaddr); end
    if (last_wmask !== 4'b1000) begin miscompares++; $display("FAIL sb wmask: got %b required 1000", last_wmask); end
    if (last_wdata !== 32'h0000_0012) begin miscompares++; $display("FAIL sb wdata: got %h required 00000012", last_wdata); end
    if (last_wen !== 1'b1) begin miscompares++; $display("FAIL sb wen: got %b required 1", last_wen); end
    do_req(32'h8000_0000, 0, 1, 0, 2'd2, 0, 5'd10, "lw_readback");
  endtask

  task automatic test_illegal;
    int a0, w0, d0;
    a0 = ar_cycles; w0 = aw_cycles; d0 = w_cycles;
    do_req(32'h8000_0002, 0, 1, 0, 2'd2, 0, 5'd11, "lw_misaligned");
    do_req(32'h8000_0001, 32'h55, 0, 1, 2'd1, 0, 5'd12, "sh_misaligned");
    do_req(32'h8000_0000, 0, 1, 1, 2'd0, 0, 5'd13, "ren_and_wen");
    do_req(32'h8000_0000, 0, 1, 0, 2'd3, 0, 5'd14, "size3");
    vectors++;
    if (ar_cycles != a0 || aw_cycles != w0 || w_cycles != d0) begin
      miscompares++;
      $display("FAIL illegal_no_access: ar/aw/w valid cycles %0d/%0d/%0d required 0/0/0",
               ar_cycles - a0, aw_cycles - w0, w_cycles - d0);
    end
  endtask

  task automatic test_latency;
    exp_t e;
    e = '{rdata: shadow[1], err: 1'b0, tag: 5'd15};
    sb_q.push_back(e);
    drive_req(32'h8000_0004, 0, 1, 0, 2'd2, 0, 5'd15);
    @(posedge clk); #1; req_valid = 1'b0;
    vectors += 3;
    if (dmem_arvalid !== 1'b1 || dmem_araddr !== 32'h8000_0004) begin
      miscompares++; $display("FAIL lat_ar: arvalid=%b araddr=%h required 1 80000004", dmem_arvalid, dmem_araddr);
    end
    @(posedge clk); #1;
    if (dmem_rready !== 1'b1 || dmem_arvalid !== 1'b0) begin
      miscompares++; $display("FAIL lat_rd: rready=%b arvalid=%b required 1 0", dmem_rready, dmem_arvalid);
    end
    @(posedge clk); #1;
    if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL lat_resp: resp_valid=%b required 1", resp_valid); end
    check_resp("lat");
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    exp_t e;
    e = '{rdata: shadow[0], err: 1'b0, tag: 5'd7};
    sb_q.push_back(e);
    resp_ready = 1'b0;
    drive_req(32'h8000_0000, 0, 1, 0, 2'd2, 0, 5'd7);
    wait_accept("bp");
    wait_resp("bp");
    drive_req(32'h8000_0004, 0, 1, 0, 2'd2, 0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors += 2;
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_tag !== e.tag) begin
        miscompares++;
        $display("FAIL bp_hold: valid=%b rdata=%h tag=%h required 1 %h %h", resp_valid, resp_rdata, resp_tag, e.rdata, e.tag);
      end
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready: got %b required 0", req_ready); end
    end
    check_resp("bp");
    resp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_release: req_ready=%b resp_valid=%b required 1 0", req_ready, resp_valid);
    end
    e = '{rdata: shadow[1], err: 1'b0, tag: 5'd8};
    sb_q.push_back(e);
    wait_accept("bp_next");
    wait_resp("bp_next");
    check_resp("bp_next");
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    logic seen = 1'b0;
    rv_block = 1'b1;
    drive_req(32'h8000_0008, 0, 1, 0, 2'd2, 0, 5'd20);
    wait_accept("rst_mid");
    while (!dmem_rready && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rv_block = 1'b0;
    vectors += 2;
    if (req_ready !== 1'b1 || dmem_rready !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_idle: req_ready=%b rready=%b required 1 0", req_ready, dmem_rready);
    end
    if (dmem_arvalid !== 1'b0 || dmem_awvalid !== 1'b0 || dmem_wvalid !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_valids: ar=%b aw=%b w=%b resp=%b required 0", dmem_arvalid, dmem_awvalid, dmem_wvalid, resp_valid);
    end
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_noresp: resp_valid seen=%b required 0", seen); end
  endtask

  task automatic test_back_to_back;
    stall_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        ld;
      sz = 2'($urandom_range(0, 2));
      ld = 1'($urandom_range(0, 1));
      a  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      if (sz == 2'd0)      a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 2'd1) a[1]   = 1'($urandom_range(0, 1));
      if (i % 7 == 6) a[0] = 1'b1;
      do_req(a, $urandom, ld, !ld, sz, 1'($urandom_range(0, 1)), 5'(i), "rand");
    end
    stall_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'h1111_1111 * i;
      shadow[i] = 32'h1111_1111 * i;
    end
    mem[0] = 32'h8899_AABB; shadow[0] = 32'h8899_AABB;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    drive_req(0, 0, 0, 0, 0, 0, 0); req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_loads;
    test_store;
    test_illegal;
    test_latency;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
